register_file_mp: RTL

Parametrised multi-port register file, the successor to the 8x8 single-write / dual-read register file. Provides DEPTH words of DATA_W bits with two write ports, NUM_RD combinational read ports, an optional hard-wired zero register, optional write-to-read bypass, and asynchronous clear. It sits in the datapath as the architectural register file feeding the ALU operand buses.

---
 rtl/register_file_mp.sv | 72 +++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-port architectural register file: two write ports (B wins on collision), NUM_RD combinational reads.
// Writes land on the rising edge; reads are zero-latency, optionally write-through; no flow control.
module register_file_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     WENA,
  input  logic [ADDR_W-1:0]        RWA,
  input  logic [DATA_W-1:0]        busWA,
  input  logic                     WENB,
  input  logic [ADDR_W-1:0]        RWB,
  input  logic [DATA_W-1:0]        busWB,
  input  logic [NUM_RD*ADDR_W-1:0] RR,
  output logic [NUM_RD*DATA_W-1:0] busR
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Word 0 is never written when it is the hard-wired zero register.
        if (!(ZERO_REG != 0 && i == 0)) begin
          if (WENB && RWB == ADDR_W'(i)) begin
            r_mem[i] <= busWB;
          end else if (WENA && RWA == ADDR_W'(i)) begin
            r_mem[i] <= busWA;
          end
        end
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_dat;

      assign w_addr = RR[k*ADDR_W +: ADDR_W];

      always_comb begin
        w_dat = r_mem[w_addr];
        if (BYPASS != 0) begin
          if (WENB && RWB == w_addr) begin
            w_dat = busWB;
          end else if (WENA && RWA == w_addr) begin
            w_dat = busWA;
          end
        end
        // Reset also masks the bypass path so outputs are 0 for any input while Rst is high.
        if ((ZERO_REG != 0 && w_addr == '0) || Rst) begin
          w_dat = '0;
        end
      end

      assign busR[k*DATA_W +: DATA_W] = w_dat;
    end
  endgenerate

endmodule
